gray_pos_tracker: RTL and testbench
===================================

GRAY_POS_TRACKER -- requirements
Module: gray_pos_tracker

Interface
REQ-001 Parameter W, default 4: width of the Gray-coded input.
REQ-002 Parameter PW, default 16: width of the accumulated position.
REQ-003 Parameter SYNC, default 2: number of input synchronizer stages, minimum 2.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 g_in  input  W  Gray-coded encoder sample; asynchronous to clk.
REQ-007 en  input  1  tracking enable.
REQ-008 clr  input  1  synchronous clear of position and fault.
REQ-009 b_out  output  W  registered binary decode of the synchronized sample.
REQ-010 pos  output  PW  signed-agnostic multi-step position count.
REQ-011 dir  output  1  last valid step direction: 1 = up, 0 = down.
REQ-012 step  output  1  one-cycle pulse per valid step.
REQ-013 rev  output  1  one-cycle pulse when b_out wraps (2^W-1 to 0, or 0 to 2^W-1).
REQ-014 err  output  1  one-cycle pulse on an invalid transition.
REQ-015 fault  output  1  sticky fault flag.

Function
REQ-016 g_in SHALL pass through SYNC flops before any use; the decode SHALL be b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
REQ-017 Latency from a stable g_in change to updated b_out, pos, step, rev and err SHALL be exactly SYNC+1 clk cycles.
REQ-018 The FSM SHALL have three states: INIT, TRACK and FAULT.
REQ-019 In INIT with en=1, the block SHALL load the current decoded value as baseline (b_prev, b_out), emit no step, and move to TRACK on the next cycle.
REQ-020 In TRACK, the block SHALL compute d=(b_new-b_prev) mod 2^W and act on it as follows:
- d=0: no action.
- d=1: pos+1, dir=1, step=1.
- d=2^W-1: pos-1, dir=0, step=1.
- any other d: err=1, fault=1, pos unchanged, and the FSM moves to FAULT.
REQ-021 In TRACK, b_prev and b_out SHALL update to b_new on every cycle, including the cycle that raises err.
REQ-022 rev SHALL pulse together with step when an up step goes from 2^W-1 to 0, or a down step goes from 0 to 2^W-1.
REQ-023 pos SHALL wrap modulo 2^PW with no saturation and no flag.
REQ-024 In FAULT, b_out SHALL keep following the input, pos SHALL be frozen, and step, rev and err SHALL stay 0.
REQ-025 The FSM SHALL leave FAULT only through clr or rst.
REQ-026 en=0 SHALL freeze pos, dir and fault and suppress all pulses; en returning to 1 SHALL enter INIT (re-baseline) unless the FSM is in FAULT.
REQ-027 clr=1 SHALL give pos=0, fault=0 and state INIT in the next cycle, with no pulses; clr SHALL win over a coincident step or err.
REQ-028 Every output SHALL be driven directly from a flop.

Reset
REQ-029 rst SHALL asynchronously set all synchronizer flops, b_prev, b_out, pos, dir, step, rev, err and fault to 0, and the state to INIT.
REQ-030 Deassertion of rst SHALL be synchronized to clk inside the block.
REQ-031 rst asserted mid-step SHALL discard the pending step; no pulse SHALL appear after release until a new transition is tracked.

Structure
REQ-032 The state encoding (INIT, TRACK, FAULT) and the default values of W, PW and SYNC SHALL be defined in a shared package gray_pkg.
REQ-033 The combinational Gray-to-binary decode SHALL be a parameterized sub-module gray_decode (width W), instantiated once.
REQ-034 The synchronizer, delta evaluation, FSM and accumulator SHALL reside in gray_pos_tracker; the block SHALL be 120-400 lines of RTL.

Verification
REQ-035 Reset and init: rst=1 then release, g_in=0110, en=1 -> b_out=0100, pos=0, no step.
REQ-036 Up sweep: g_in 0000,0001,0011,0010,...,1000,0000 (17 codes, one per 4 cycles) -> 16 step pulses, dir=1, pos=16, a single rev on the 1000->0000 transition, each pulse exactly 3 cycles after its code change.
REQ-037 Down step across zero: baseline 0000, then g_in=1000 -> pos=0xFFFF, dir=0, step=1 and rev=1 in the same cycle.
REQ-038 Invalid jump: baseline 0000 (b=0), then g_in=0011 (b=2) -> err pulse, fault=1, pos unchanged; further valid codes -> no steps.
REQ-039 Clear priority: clr=1 in the same cycle as a valid step -> pos=0, fault=0, no step; next code change after re-baseline -> pos=1.
REQ-040 Enable gating: en=0 while g_in goes 0000->0001->0011 -> pos frozen; en=1 -> INIT re-baseline to b=0010, no step.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared state encoding and default sizing for the Gray-code position tracker.
package gray_pkg;

    localparam int DEF_W    = 4;
    localparam int DEF_PW   = 16;
    localparam int DEF_SYNC = 2;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray_decode
    import gray_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);

    logic acc;

    always_comb begin
        acc = 1'b0;
        b   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
    end

endmodule

// File: rtl/gray_pos_tracker.sv
// Tracks an asynchronous Gray-coded encoder: synchronizes, decodes, classifies each
// step as up/down/invalid and accumulates a wrapping multi-turn position.
module gray_pos_tracker
    import gray_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int PW   = DEF_PW,
    parameter int SYNC = DEF_SYNC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  g_in,
    input  logic          en,
    input  logic          clr,
    output logic [W-1:0]  b_out,
    output logic [PW-1:0] pos,
    output logic          dir,
    output logic          step,
    output logic          rev,
    output logic          err,
    output logic          fault
);

    // Fewer than two stages would not give metastability time to resolve.
    localparam int NS = (SYNC < 2) ? 2 : SYNC;

    logic [W-1:0]  sync_q [NS];
    logic [NS-1:0] rst_pipe;
    logic          hold;
    logic [W-1:0]  b_new;
    logic [W-1:0]  b_prev;
    logic [W-1:0]  delta;
    state_t        state;
    state_t        state_n;
    logic [W-1:0]  b_prev_n;
    logic [W-1:0]  b_out_n;
    logic [PW-1:0] pos_n;
    logic          dir_n;
    logic          step_n;
    logic          rev_n;
    logic          err_n;
    logic          fault_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= g_in;
            for (int i = 1; i < NS; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Release of rst is held off NS cycles, so the first baseline sees a filled synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[NS-2:0], 1'b1};
        end
    end

    assign hold = ~rst_pipe[NS-1];

    gray_decode #(.W(W)) u_decode (
        .g (sync_q[NS-1]),
        .b (b_new)
    );

    assign delta = b_new - b_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INIT;
            b_prev <= '0;
            b_out  <= '0;
            pos    <= '0;
            dir    <= 1'b0;
            step   <= 1'b0;
            rev    <= 1'b0;
            err    <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_n;
            b_prev <= b_prev_n;
            b_out  <= b_out_n;
            pos    <= pos_n;
            dir    <= dir_n;
            step   <= step_n;
            rev    <= rev_n;
            err    <= err_n;
            fault  <= fault_n;
        end
    end

    // b_out and b_prev follow the decoded sample in every state; INIT simply skips classification.
    always_comb begin
        state_n  = state;
        b_prev_n = b_prev;
        b_out_n  = b_out;
        pos_n    = pos;
        dir_n    = dir;
        step_n   = 1'b0;
        rev_n    = 1'b0;
        err_n    = 1'b0;
        fault_n  = fault;

        if (hold) begin
            state_n  = INIT;
            b_prev_n = '0;
            b_out_n  = '0;
            pos_n    = '0;
            dir_n    = 1'b0;
            fault_n  = 1'b0;
        end else begin
            b_prev_n = b_new;
            b_out_n  = b_new;
            if (clr) begin
                pos_n   = '0;
                fault_n = 1'b0;
                state_n = INIT;
            end else if (!en) begin
                if (state != FAULT) begin
                    state_n = INIT;
                end
            end else begin
                case (state)
                    INIT: begin
                        state_n = TRACK;
                    end
                    TRACK: begin
                        if (delta == W'(1)) begin
                            pos_n  = pos + PW'(1);
                            dir_n  = 1'b1;
                            step_n = 1'b1;
                            rev_n  = (b_prev == '1);
                        end else if (delta == '1) begin
                            pos_n  = pos - PW'(1);
                            dir_n  = 1'b0;
                            step_n = 1'b1;
                            rev_n  = (b_prev == '0);
                        end else if (delta != '0) begin
                            err_n   = 1'b1;
                            fault_n = 1'b1;
                            state_n = FAULT;
                        end
                    end
                    FAULT: begin
                        state_n = FAULT;
                    end
                    default: begin
                        state_n = INIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Scoreboard bench for gray_pos_tracker: expected outputs are queued when a code is driven
// and popped when the registered result is due, SYNC+1 = 3 cycles later.
module tb_gray_pos_tracker;

    typedef struct packed {
        logic [3:0]  b;
        logic [15:0] pos;
        logic        dir;
        logic        step;
        logic        rev;
        logic        err;
        logic        fault;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [3:0]  g_in;
    logic [3:0]  b_out;
    logic [15:0] pos;
    logic        dir;
    logic        step;
    logic        rev;
    logic        err;
    logic        fault;
    obs_t        obs;

    int          n_cmp;
    int          n_bad;
    obs_t        sb[$];

    logic [3:0]  m_bprev;
    logic [15:0] m_pos;
    logic        m_dir;
    logic        m_fault;

    gray_pos_tracker #(.W(4), .PW(16), .SYNC(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .g_in  (g_in),
        .en    (en),
        .clr   (clr),
        .b_out (b_out),
        .pos   (pos),
        .dir   (dir),
        .step  (step),
        .rev   (rev),
        .err   (err),
        .fault (fault)
    );

    always #5 clk = ~clk;

    assign obs = {b_out, pos, dir, step, rev, err, fault};

    function automatic logic [3:0] tb_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("b=%h pos=%h dir=%b step=%b rev=%b err=%b fault=%b",
                         o.b, o.pos, o.dir, o.step, o.rev, o.err, o.fault);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] g);
        rst  = 1'b1;
        en   = 1'b1;
        clr  = 1'b0;
        g_in = g;
        tick(2);
        rst = 1'b0;
        tick(5);
        m_bprev = tb_g2b(g);
        m_pos   = 16'h0;
        m_dir   = 1'b0;
        m_fault = 1'b0;
        sb.delete();
    endtask

    // Drives a new code with en=1, clr=0 and queues the result the model predicts.
    task automatic drive_code(input logic [3:0] g);
        obs_t       e;
        logic [3:0] nb;
        logic [3:0] d;
        g_in = g;
        nb   = tb_g2b(g);
        e    = '0;
        if (!m_fault) begin
            d = nb - m_bprev;
            if (d == 4'd1) begin
                m_pos  = m_pos + 16'd1;
                m_dir  = 1'b1;
                e.step = 1'b1;
                e.rev  = (m_bprev == 4'hF);
            end else if (d == 4'hF) begin
                m_pos  = m_pos - 16'd1;
                m_dir  = 1'b0;
                e.step = 1'b1;
                e.rev  = (m_bprev == 4'h0);
            end else if (d != 4'd0) begin
                e.err   = 1'b1;
                m_fault = 1'b1;
            end
        end
        m_bprev = nb;
        e.b     = nb;
        e.pos   = m_pos;
        e.dir   = m_dir;
        e.fault = m_fault;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        en   = 1'b1;
        clr  = 1'b0;
        g_in = 4'b0110;
        tick(2);
        n_cmp++;
        if (obs !== 25'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_state: got %s, required all zero", fmt(obs));
        end
        rst = 1'b0;
        tick(5);
        n_cmp++;
        if ({b_out, pos, step} !== {4'b0100, 16'h0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_init: got b=%b pos=%h step=%b, required b=0100 pos=0000 step=0",
                     b_out, pos, step);
        end
    endtask

    task automatic test_up_sweep;
        obs_t       e;
        logic [3:0] bb;
        int         revs;
        revs = 0;
        do_reset(4'b0000);
        for (int i = 1; i <= 16; i++) begin
            bb = 4'(i % 16);
            drive_code(bb ^ (bb >> 1));
            tick(2);
            n_cmp++;
            if (step !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL sweep_early[%0d]: step=%b, required 0", i, step);
            end
            tick(1);
            e = sb.pop_front();
            if (rev === 1'b1) revs++;
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("[TB] FAIL sweep[%0d]: got %s, required %s", i, fmt(obs), fmt(e));
            end
            tick(1);
        end
        n_cmp++;
        if ({pos, dir, revs} !== {16'd16, 1'b1, 32'd1}) begin
            n_bad++;
            $display("[TB] FAIL sweep_total: got pos=%0d dir=%b revs=%0d, required pos=16 dir=1 revs=1",
                     pos, dir, revs);
        end
    endtask

    task automatic test_down_wrap;
        obs_t e;
        do_reset(4'b0000);
        drive_code(4'b1000);
        tick(3);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL down_wrap: got %s, required %s", fmt(obs), fmt(e));
        end
        n_cmp++;
        if ({pos, dir, step, rev} !== {16'hFFFF, 1'b0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL down_wrap_abs: got pos=%h dir=%b step=%b rev=%b, required FFFF 0 1 1",
                     pos, dir, step, rev);
        end
        tick(1);
    endtask

    task automatic test_invalid_jump;
        obs_t e;
        logic [3:0] codes [3];
        codes[0] = 4'b0011;
        codes[1] = 4'b0010;
        codes[2] = 4'b0110;
        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive_code(codes[i]);
            tick(3);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("[TB] FAIL invalid[%0d]: got %s, required %s", i, fmt(obs), fmt(e));
            end
            tick(1);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_cmp++;
        if ({pos, step, err, fault} !== {16'h0, 3'b000}) begin
            n_bad++;
            $display("[TB] FAIL fault_clear: got pos=%h step=%b err=%b fault=%b, required 0000 0 0 0",
                     pos, step, err, fault);
        end
        m_fault = 1'b0;
        m_pos   = 16'h0;
        m_bprev = 4'd4;
        tick(2);
        drive_code(4'b0111);
        tick(3);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL after_fault_clear: got %s, required %s", fmt(obs), fmt(e));
        end
        tick(1);
    endtask

    task automatic test_clear_priority;
        obs_t e;
        do_reset(4'b0000);
        drive_code(4'b0001);
        tick(3);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL clr_setup: got %s, required %s", fmt(obs), fmt(e));
        end
        tick(1);
        g_in = 4'b0011;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_cmp++;
        if ({pos, step, rev, err, fault} !== {16'h0, 4'b0000}) begin
            n_bad++;
            $display("[TB] FAIL clr_priority: got pos=%h step=%b rev=%b err=%b fault=%b, required 0000 0 0 0 0",
                     pos, step, rev, err, fault);
        end
        m_pos   = 16'h0;
        m_fault = 1'b0;
        m_bprev = 4'd2;
        tick(2);
        drive_code(4'b0010);
        tick(3);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL clr_rebase_step: got %s, required %s", fmt(obs), fmt(e));
        end
        tick(1);
    endtask

    task automatic test_enable_gating;
        obs_t e;
        do_reset(4'b1000);
        drive_code(4'b0000);
        tick(3);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL en_setup: got %s, required %s", fmt(obs), fmt(e));
        end
        tick(1);
        en = 1'b0;
        tick(1);
        g_in = 4'b0001;
        tick(3);
        n_cmp++;
        if ({pos, dir, step, rev, err, fault} !== {16'd1, 5'b10000}) begin
            n_bad++;
            $display("[TB] FAIL en_freeze_a: got pos=%h dir=%b step=%b rev=%b err=%b fault=%b, required 0001 1 0 0 0 0",
                     pos, dir, step, rev, err, fault);
        end
        tick(1);
        g_in = 4'b0011;
        tick(3);
        n_cmp++;
        if ({pos, dir, step, rev, err, fault} !== {16'd1, 5'b10000}) begin
            n_bad++;
            $display("[TB] FAIL en_freeze_b: got pos=%h dir=%b step=%b rev=%b err=%b fault=%b, required 0001 1 0 0 0 0",
                     pos, dir, step, rev, err, fault);
        end
        tick(1);
        en = 1'b1;
        tick(3);
        e = '{b: 4'b0010, pos: 16'd1, dir: 1'b1, step: 1'b0, rev: 1'b0, err: 1'b0, fault: 1'b0};
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL en_rebase: got %s, required %s", fmt(obs), fmt(e));
        end
        m_bprev = 4'd2;
        drive_code(4'b0010);
        tick(3);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL en_resume: got %s, required %s", fmt(obs), fmt(e));
        end
        tick(1);
    endtask

    task automatic test_reset_mid_step;
        obs_t e;
        int   pulses;
        pulses = 0;
        do_reset(4'b0000);
        drive_code(4'b0001);
        tick(3);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL midrst_setup: got %s, required %s", fmt(obs), fmt(e));
        end
        tick(1);
        g_in = 4'b0011;
        tick(1);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 25'h0) begin
            n_bad++;
            $display("[TB] FAIL midrst_async: got %s, required all zero", fmt(obs));
        end
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (step === 1'b1 || err === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("[TB] FAIL midrst_pulses: got %0d pulses, required 0", pulses);
        end
        e = '{b: 4'b0010, pos: 16'h0, dir: 1'b0, step: 1'b0, rev: 1'b0, err: 1'b0, fault: 1'b0};
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("[TB] FAIL midrst_state: got %s, required %s", fmt(obs), fmt(e));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        en    = 1'b1;
        clr   = 1'b0;
        g_in  = 4'b0000;
        test_reset;
        test_up_sweep;
        test_down_wrap;
        test_invalid_jump;
        test_clear_priority;
        test_enable_gating;
        test_reset_mid_step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
